// File: rtl/cosinehw_pkg.sv
// Shared types and constants for the cosine-similarity job scheduler.
// Contents:
//   SchedVecWidth / SchedTagWidth : default packed vector and tag widths
//   SchedTimeoutDefault           : default engine timeout in cycles
//   sched_state_e                 : scheduler FSM states
//   sched_job_t                   : one queued job (A vector, B vector, tag)
package cosinehw_pkg;

  localparam int unsigned SchedVecWidth       = 32;
  localparam int unsigned SchedTagWidth       = 4;
  localparam int unsigned SchedTimeoutDefault = 1024;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLaunch   = 2'd1,
    StWaitDone = 2'd2,
    StRelease  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [SchedVecWidth-1:0] avec;
    logic [SchedVecWidth-1:0] bvec;
    logic [SchedTagWidth-1:0] tag;
  } sched_job_t;

endpackage

// File: rtl/cosinehw_sched_fifo.sv
// Synchronous job FIFO with registered occupancy count.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write wdata_i (accepted when not full, or when popping the same cycle)
//   wdata_i       : entry to write
//   pop_i         : drop the head entry (ignored when empty)
//   rdata_o       : head entry (valid while !empty_o)
//   full_o        : Depth entries stored
//   empty_o       : no entries stored
//   count_o       : number of stored entries
module cosinehw_sched_fifo
  import cosinehw_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter type entry_t = sched_job_t,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  entry_t          wdata_i,
  input  logic            pop_i,
  output entry_t          rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cosinehw_sched.sv
// Job sequencer in front of the cosine-similarity engine. Buffers (A,B,tag) jobs in a FIFO,
// runs one engine computation at a time over a level start/done handshake, and returns each
// result with its tag on a valid/ready port.
// Optional feature: define COSINEHW_SCHED_TIMEOUT_EN to add an engine timeout (TimeoutCycles);
// a timed-out job returns an all-ones result and sets the sticky err_o.
// Ports:
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   job_valid_i/job_ready_o        : job handshake; job_avec_i, job_bvec_i, job_tag_i payload
//   eng_start_o, eng_avec_o/bvec_o : engine start level and operands
//   eng_done_i, eng_cos_i          : engine done level and result
//   res_valid_o/res_ready_i        : result handshake; res_cos_o, res_tag_o payload
//   busy_o                         : job in flight, queued, or result pending
//   err_o                          : sticky timeout error (0 without the timeout feature)
module cosinehw_sched
  import cosinehw_pkg::*;
#(
  parameter int unsigned JobDepth = 4,
  parameter int unsigned TagWidth = SchedTagWidth,
  parameter int unsigned VecWidth = SchedVecWidth,
  parameter int unsigned CosWidth = 16
`ifdef COSINEHW_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TimeoutCycles = SchedTimeoutDefault
`endif
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  logic [VecWidth-1:0] job_avec_i,
  input  logic [VecWidth-1:0] job_bvec_i,
  input  logic [TagWidth-1:0] job_tag_i,
  output logic                eng_start_o,
  output logic [VecWidth-1:0] eng_avec_o,
  output logic [VecWidth-1:0] eng_bvec_o,
  input  logic                eng_done_i,
  input  logic [CosWidth-1:0] eng_cos_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [CosWidth-1:0] res_cos_o,
  output logic [TagWidth-1:0] res_tag_o,
  output logic                busy_o,
  output logic                err_o
);

  typedef struct packed {
    logic [VecWidth-1:0] avec;
    logic [VecWidth-1:0] bvec;
    logic [TagWidth-1:0] tag;
  } job_t;

  localparam int unsigned CntW = $clog2(JobDepth) + 1;

  sched_state_e        state_q, state_d;
  job_t                act_q, fifo_wdata, fifo_rdata;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]     fifo_count;
  logic                init_q;
  logic                capture, timeout, to_hit;
  logic                res_valid_q;
  logic [CosWidth-1:0] res_cos_q;
  logic [TagWidth-1:0] res_tag_q;

  // Holds job_ready_o low while in reset and for the first cycle after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) init_q <= 1'b0;
    else         init_q <= 1'b1;
  end

  assign job_ready_o     = init_q & ~fifo_full;
  assign fifo_push       = job_valid_i & job_ready_o;
  assign fifo_wdata.avec = job_avec_i;
  assign fifo_wdata.bvec = job_bvec_i;
  assign fifo_wdata.tag  = job_tag_i;

  cosinehw_sched_fifo #(
    .Depth   (JobDepth),
    .entry_t (job_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StLaunch;
        end
      end
      // Done is not looked at here, so a stale done from the previous job is ignored.
      StLaunch: state_d = StWaitDone;
      StWaitDone: begin
        if (eng_done_i) begin
          capture = 1'b1;
          state_d = StRelease;
        end else if (to_hit) begin
          capture = 1'b1;
          timeout = 1'b1;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!eng_done_i && (!res_valid_q || res_ready_i)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Operands only change in IDLE, so they are stable for the whole engine run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       act_q <= '0;
    else if (fifo_pop) act_q <= fifo_rdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_cos_q   <= '0;
      res_tag_q   <= '0;
    end else if (capture) begin
      res_valid_q <= 1'b1;
      res_cos_q   <= timeout ? '1 : eng_cos_i;
      res_tag_q   <= act_q.tag;
    end else if (res_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

`ifdef COSINEHW_SCHED_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == StLaunch)        to_cnt_q <= '0;
      else if (state_q == StWaitDone) to_cnt_q <= to_cnt_q + ToW'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  // Fires on the TimeoutCycles-th cycle spent in WAIT_DONE.
  assign to_hit = (32'(to_cnt_q) == (TimeoutCycles - 1));
  assign err_o  = err_q;
`else
  assign to_hit = 1'b0;
  assign err_o  = 1'b0;
`endif

  assign eng_start_o = (state_q == StLaunch) | (state_q == StWaitDone);
  assign eng_avec_o  = act_q.avec;
  assign eng_bvec_o  = act_q.bvec;
  assign res_valid_o = res_valid_q;
  assign res_cos_o   = res_cos_q;
  assign res_tag_o   = res_tag_q;
  assign busy_o      = (state_q != StIdle) | (|fifo_count) | res_valid_q;

endmodule

// File: tb/tb_cosinehw_sched.sv
// Scoreboard bench for cosinehw_sched with a behavioural engine model.
// Engine result = avec[15:0] + bvec[31:16] (16-bit wrap); expected values are hand-computed.
module tb_cosinehw_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid, job_ready;
  logic [31:0] job_avec, job_bvec;
  logic [3:0]  job_tag;
  logic        eng_start, eng_done;
  logic [31:0] eng_avec, eng_bvec;
  logic [15:0] eng_cos;
  logic        res_valid, res_ready;
  logic [15:0] res_cos;
  logic [3:0]  res_tag;
  logic        busy, err;

  always #5 clk = ~clk;

  cosinehw_sched #(
    .JobDepth (4),
    .TagWidth (4),
    .VecWidth (32),
    .CosWidth (16)
`ifdef COSINEHW_SCHED_TIMEOUT_EN
    ,
    .TimeoutCycles (16)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .job_valid_i (job_valid),
    .job_ready_o (job_ready),
    .job_avec_i  (job_avec),
    .job_bvec_i  (job_bvec),
    .job_tag_i   (job_tag),
    .eng_start_o (eng_start),
    .eng_avec_o  (eng_avec),
    .eng_bvec_o  (eng_bvec),
    .eng_done_i  (eng_done),
    .eng_cos_i   (eng_cos),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_cos_o   (res_cos),
    .res_tag_o   (res_tag),
    .busy_o      (busy),
    .err_o       (err)
  );

  // Engine model: raises done eng_lat cycles after start, holds it until start drops.
  int   eng_lat;
  logic eng_hang, stale_done, done_m;
  int   eng_cnt;
  logic [15:0] cos_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_cnt <= 0;
      done_m  <= 1'b0;
      cos_m   <= '0;
    end else if (eng_start) begin
      if (!done_m && !eng_hang) begin
        if (eng_cnt == eng_lat - 1) begin
          done_m <= 1'b1;
          cos_m  <= eng_avec[15:0] + eng_bvec[31:16];
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
    end else begin
      eng_cnt <= 0;
      done_m  <= 1'b0;
    end
  end

  assign eng_done = done_m | stale_done;
  assign eng_cos  = cos_m;

  typedef struct packed {
    logic [3:0]  tag;
    logic [15:0] cos;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   launches = 0;
  logic start_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every result handshake against the scoreboard head.
  always @(negedge clk) begin
    if (eng_start && !start_prev) launches++;
    start_prev = eng_start;
    if (rst_n && res_valid && res_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got tag %0d cos 0x%0h, required no result",
                 res_tag, res_cos);
      end else begin
        mon_e = sb_q.pop_front();
        if (res_tag !== mon_e.tag || res_cos !== mon_e.cos) begin
          errors++;
          $display("FAIL result: got tag %0d cos 0x%0h, required tag %0d cos 0x%0h",
                   res_tag, res_cos, mon_e.tag, mon_e.cos);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the edge that accepted the job.
  task automatic push_job(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] e, input bit expect_res);
    int n = 0;
    exp_t x;
    job_valid = 1'b1;
    job_tag   = t;
    job_avec  = a;
    job_bvec  = b;
    forever begin
      @(negedge clk);
      if (job_ready) break;
      n++;
      if (n > 500) begin
        chk("push_timeout", 32'(job_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    if (expect_res) begin
      x.tag = t;
      x.cos = e;
      sb_q.push_back(x);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
    chk({name, "_idle"}, 32'(busy), 32'd0);
    step();
  endtask

  logic [31:0] fill_a [5] = '{32'h00000010, 32'h000000FF, 32'h00001000, 32'h0000FFFF,
                              32'hDEADBEEF};
  logic [31:0] fill_b [5] = '{32'h00010000, 32'h00020000, 32'h10000000, 32'h00010000,
                              32'hCAFE0000};
  logic [15:0] fill_e [5] = '{16'h0011, 16'h0101, 16'h2000, 16'h0000, 16'h89ED};

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int l0;
    int changes;
    rst_n = 1'b0;
    job_valid = 1'b0;
    job_avec = '0;
    job_bvec = '0;
    job_tag = '0;
    res_ready = 1'b1;
    stale_done = 1'b0;
    eng_hang = 1'b0;
    eng_lat = 10;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_job_ready", 32'(job_ready), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_eng_avec", eng_avec, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", 32'(job_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(job_ready), 32'd1);
    step();

    // Single job, 10-cycle engine
    push_job(4'd3, 32'h01020304, 32'h01020304, 16'h0406, 1'b1);
    @(negedge clk);
    chk("t1_start_pop_cycle", 32'(eng_start), 32'd0);
    @(negedge clk);
    chk("t1_start_launch", 32'(eng_start), 32'd1);
    chk("t1_avec", eng_avec, 32'h01020304);
    chk("t1_busy", 32'(busy), 32'd1);
    k = 0;
    while (!eng_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t1_done_latency", k, 32'd10);
    chk("t1_start_held", 32'(eng_start), 32'd1);
    @(negedge clk);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    chk("t1_start_dropped", 32'(eng_start), 32'd0);
    drain("t1_drain");

    // Fill the FIFO with the engine stalled
    eng_hang = 1'b1;
    eng_lat = 3;
    for (int i = 0; i < 5; i++) push_job(4'(i), fill_a[i], fill_b[i], fill_e[i], 1'b1);
    @(negedge clk);
    chk("t2_full_ready_low", 32'(job_ready), 32'd0);
    chk("t2_start_held", 32'(eng_start), 32'd1);
    eng_hang = 1'b0;
    k = 0;
    while (!job_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t2_ready_with_launch", 32'(eng_start), 32'd1);
    chk("t2_next_avec", eng_avec, fill_a[1]);
    drain("t2_drain");

    // Result back-pressure
    res_ready = 1'b0;
    eng_lat = 4;
    push_job(4'd5, 32'h00000001, 32'h00010000, 16'h0002, 1'b1);
    push_job(4'd6, 32'h00008000, 32'h7FFF0000, 16'hFFFF, 1'b1);
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t3_tag", 32'(res_tag), 32'd5);
    chk("t3_cos", 32'(res_cos), 32'h0002);
    l0 = launches;
    changes = 0;
    repeat (50) begin
      @(negedge clk);
      if (res_tag !== 4'd5 || res_cos !== 16'h0002 || res_valid !== 1'b1) changes++;
    end
    chk("t3_stable", changes, 32'd0);
    chk("t3_no_relaunch", launches, l0);
    chk("t3_start_low", 32'(eng_start), 32'd0);
    chk("t3_queued_busy", 32'(busy), 32'd1);
    step();
    res_ready = 1'b1;
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (eng_start) break;
    end
    chk("t3_relaunch_within_3", 32'(eng_start && k <= 3), 32'd1);
    drain("t3_drain");

    // Stale done in IDLE and LAUNCH is ignored
    stale_done = 1'b1;
    eng_lat = 5;
    repeat (3) @(negedge clk);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_no_result", 32'(res_valid), 32'd0);
    step();
    push_job(4'd7, 32'h00000100, 32'h00020000, 16'h0102, 1'b1);
    @(negedge clk);
    chk("t4_pop_no_result", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("t4_launch", 32'(eng_start), 32'd1);
    step();
    stale_done = 1'b0;
    @(negedge clk);
    chk("t4_still_waiting", 32'(eng_start), 32'd1);
    chk("t4_no_early_result", 32'(res_valid), 32'd0);
    drain("t4_drain");

    // Reset during WAIT_DONE, with another job queued
    eng_hang = 1'b1;
    push_job(4'd8, 32'hAAAA5555, 32'h5555AAAA, 16'h0000, 1'b0);
    push_job(4'd10, 32'h11112222, 32'h33334444, 16'h0000, 1'b0);
    k = 0;
    while (!eng_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("t5_pre_reset_start", 32'(eng_start), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_start", 32'(eng_start), 32'd0);
    chk("t5_rst_ready", 32'(job_ready), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_avec", eng_avec, 32'd0);
    eng_hang = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_ready_after", 32'(job_ready), 32'd1);
    chk("t5_fifo_empty", 32'(busy), 32'd0);
    step();
    eng_lat = 4;
    push_job(4'd9, 32'h00000005, 32'h00060000, 16'h000B, 1'b1);
    drain("t5_drain");

`ifdef COSINEHW_SCHED_TIMEOUT_EN
    // Engine never finishes: all-ones result after 16 cycles, sticky error
    eng_hang = 1'b1;
    push_job(4'd12, 32'h12345678, 32'h9ABCDEF0, 16'hFFFF, 1'b1);
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_err_set", 32'(err), 32'd1);
    drain("t6_drain");
    eng_hang = 1'b0;
    push_job(4'd13, 32'h00000007, 32'h00080000, 16'h000F, 1'b1);
    drain("t6_next_drain");
    chk("t6_err_sticky", 32'(err), 32'd1);
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cosinehw_sched.md
Name: cosinehw_sched

Overview:
- Job sequencer in front of the cosine-similarity engine (`control_store`).
- Accepts queued (A,B) vector-pair jobs over a valid/ready port and buffers them in a small FIFO.
- Launches one engine computation at a time and handles the level-based start/done handshake.
- Returns each 16-bit cosine result, tagged with its job ID, on a valid/ready result port. Software or a DMA can therefore stream jobs without polling the done register.

Parameters:
- `JobDepth`, 4, job FIFO depth; power of two, ≥2.
- `TagWidth`, 4, width of the job tag carried to the result.
- `VecWidth`, 32, packed vector width for A and B.
- `CosWidth`, 16, result width.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `job_valid_i`  in  1  job offered
- `job_ready_o`  out  1  FIFO not full
- `job_avec_i`  in  VecWidth  A vector
- `job_bvec_i`  in  VecWidth  B vector
- `job_tag_i`  in  TagWidth  job ID
- `eng_start_o`  out  1  engine start level
- `eng_avec_o`  out  VecWidth  A to engine
- `eng_bvec_o`  out  VecWidth  B to engine
- `eng_done_i`  in  1  engine done level
- `eng_cos_i`  in  CosWidth  engine result
- `res_valid_o`  out  1  result available
- `res_ready_i`  in  1  result consumed
- `res_cos_o`  out  CosWidth  cosine result
- `res_tag_o`  out  TagWidth  tag of result
- `busy_o`  out  1  FSM not IDLE or FIFO not empty
- `err_o`  out  1  sticky error (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE. `job_ready_o` rises the first cycle after reset release.
- Job FIFO:
  - Push on `job_valid_i & job_ready_o`.
  - `job_ready_o = !full`, registered count, no combinational path from `job_valid_i`.
  - Push and pop in the same cycle are legal; a push into a full FIFO is legal only when a pop occurs that same cycle.
  - Pointers wrap modulo `JobDepth`; count is `$clog2(JobDepth)+1` bits.
- FSM states:
  - IDLE: if FIFO not empty, pop the head into the active registers (A, B, tag) and go to LAUNCH next cycle.
  - LAUNCH: assert `eng_start_o` with `eng_avec_o`/`eng_bvec_o` from the active registers; go to WAIT_DONE.
  - WAIT_DONE: keep `eng_start_o` = 1. When `eng_done_i` = 1, capture `eng_cos_i` into the result register, drop `eng_start_o` in the same edge, set `res_valid_o`, and go to RELEASE.
  - RELEASE: `eng_start_o` = 0. Wait until `eng_done_i` = 0 (engine back to idle) AND the result slot is free (`!res_valid_o`, or handshake this cycle); then go to IDLE.
- Latency: job push to `eng_start_o` high is 3 cycles with an empty FIFO and idle FSM (push, pop, LAUNCH). Result appears the cycle after `eng_done_i` is sampled high.
- Engine operands are stable from LAUNCH through RELEASE; the active registers change only in IDLE.
- Result port:
  - `res_valid_o` held with `res_cos_o`/`res_tag_o` stable until `res_ready_i`.
  - A result handshake in the same cycle as a new capture keeps `res_valid_o` high with the new data.
  - Back-pressure stalls in RELEASE; the FIFO keeps accepting jobs until full.
- `eng_done_i` high in IDLE or LAUNCH (stale done): ignored. The FSM leaves WAIT_DONE only on done sampled in WAIT_DONE, after start has been high ≥1 cycle.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); queued jobs are lost; `eng_start_o` drops asynchronously.
- `busy_o = (state != IDLE) | !empty | res_valid_o`.
- Without the optional feature, `err_o` is tied 0.

Optional Feature:
- Macro `COSINEHW_SCHED_TIMEOUT_EN`.
- Defined:
  - Parameter `TimeoutCycles` (default 1024) and a counter cleared on LAUNCH, incrementing in WAIT_DONE.
  - On reaching `TimeoutCycles`: drop `eng_start_o`, produce a result with `res_cos_o` = all ones and the job's tag, set sticky `err_o`, go to RELEASE.
  - `err_o` clears only on reset.
- Undefined: no counter; WAIT_DONE waits indefinitely; `err_o` = 0.

Decomposition:
- `cosinehw_pkg` gains:
  - FSM state enum `sched_state_e` (IDLE, LAUNCH, WAIT_DONE, RELEASE).
  - Job struct `sched_job_t` (avec, bvec, tag).
  - `SchedTimeoutDefault` constant.
- Sub-module `cosinehw_sched_fifo`: parameterized synchronous FIFO of `sched_job_t` with full/empty/count.

Test Plan:
- Single job: push A=0x01020304, B=0x01020304, tag 3 into an engine model with 10-cycle done → `eng_start_o` high 3 cycles after push, held until done; `res_valid_o` with `res_tag_o`=3 and the model cos value one cycle after done; `busy_o` low once result taken and done low.
- Fill FIFO: push 5 jobs back-to-back, engine stalled → `job_ready_o` low after 4 accepted while 1 is active; `job_ready_o` reasserts the cycle after pop; results return in tag order 0..4.
- Result back-pressure: hold `res_ready_i`=0 for 50 cycles → `res_*` stable, FSM parked in RELEASE, no second `eng_start_o`; release → next job launches within 3 cycles.
- Stale done: hold `eng_done_i`=1 in IDLE, then push a job → LAUNCH/WAIT_DONE not completed until done is seen in WAIT_DONE.
- Reset mid-job: assert `rst_ni` low during WAIT_DONE → all outputs 0 the same cycle; after release `job_ready_o`=1 and FIFO empty.
- With `COSINEHW_SCHED_TIMEOUT_EN`, TimeoutCycles=16, engine never done → result 0xFFFF with correct tag after 16 cycles; `err_o`=1 sticky; next job still executes.
